// File: rtl/snake_dir_queue_if.sv
// Request/control/status bundle of the snake direction queue.
// The DUT takes the slave side; whoever drives the key levels takes the master side.
interface snake_dir_queue_if #(
   parameter int NSRC  = 2,
   parameter int DEPTH = 2
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [NSRC-1:0] src_up;
   logic [NSRC-1:0] src_right;
   logic [NSRC-1:0] src_down;
   logic [NSRC-1:0] src_left;
   logic            step;
   logic            clear;
   logic [1:0]      direction;
   logic [CW-1:0]   queue_count;
   logic            turned;
   logic            overflow;

   modport master (
      output src_up, src_right, src_down, src_left, step, clear,
      input  direction, queue_count, turned, overflow
   );

   modport slave (
      input  src_up, src_right, src_down, src_left, step, clear,
      output direction, queue_count, turned, overflow
   );
endinterface

// File: rtl/snake_dir_queue.sv
// Snake heading controller: merges and edge-detects turn keys, buffers legal turns
// in a small circular FIFO and applies one queued turn per game step.
module snake_dir_queue #(
   parameter int         NSRC          = 2,
   parameter int         DEPTH         = 2,
   parameter logic [1:0] INIT_DIR      = 2'b01,
   parameter bit         ALLOW_REVERSE = 1'b0
) (
   input logic              clock,
   input logic              reset,
   snake_dir_queue_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // level/press bit order: {up, right, down, left}
   logic [3:0]    lvl;
   logic [3:0]    prev_lvl;
   logic [3:0]    press;
   logic [1:0]    cand;
   logic          cand_valid;

   logic [1:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] tail_ptr;
   logic [CW-1:0] count;
   logic [1:0]    dir_q;
   logic          turned_q;
   logic          overflow_q;

   logic [1:0]    ref_dir;
   logic          is_empty;
   logic          is_full;
   logic          legal;
   logic          pop;
   logic          push;
   logic          drop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign lvl   = {|bus.src_up, |bus.src_right, |bus.src_down, |bus.src_left};
   assign press = lvl & ~prev_lvl;

   // only one press per cycle is considered: LEFT > RIGHT > UP > DOWN
   always_comb begin
      cand       = 2'b00;
      cand_valid = 1'b1;
      if (press[0])      cand = 2'b11;
      else if (press[2]) cand = 2'b01;
      else if (press[3]) cand = 2'b00;
      else if (press[1]) cand = 2'b10;
      else               cand_valid = 1'b0;
   end

   assign tail_ptr = (wr_ptr == '0) ? PW'(DEPTH - 1) : wr_ptr - 1'b1;
   assign is_empty = (count == '0);
   assign is_full  = (count == CW'(DEPTH));
   assign ref_dir  = is_empty ? dir_q : mem[tail_ptr];

   // judged against the pre-pop tail so a turn queued behind the head stays consistent
   assign legal = cand_valid && (cand != ref_dir) &&
                  (ALLOW_REVERSE || (cand != (ref_dir ^ 2'b10)));
   assign pop   = bus.step && !is_empty && !bus.clear;
   assign push  = legal && !bus.clear && (!is_full || pop);
   assign drop  = legal && !bus.clear && is_full && !pop;

   always_ff @(posedge clock) begin
      if (reset) begin
         prev_lvl   <= 4'hF;
         dir_q      <= INIT_DIR;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         turned_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         prev_lvl   <= lvl;
         turned_q   <= 1'b0;
         overflow_q <= 1'b0;
         if (bus.clear) begin
            dir_q  <= INIT_DIR;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (pop) begin
               dir_q    <= mem[rd_ptr];
               rd_ptr   <= ptr_inc(rd_ptr);
               turned_q <= 1'b1;
            end
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            overflow_q <= drop;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= cand;
   end

   assign bus.direction   = dir_q;
   assign bus.queue_count = count;
   assign bus.turned      = turned_q;
   assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_snake_dir_queue.sv
// Bench for snake_dir_queue: a directed vector table plus random traffic, two
// configurations (DEPTH=2 no-reverse, DEPTH=3 reverse-allowed) checked against a queue model.
module tb_snake_dir_queue;
   logic clock;
   logic reset;
   int   n_chk  = 0;
   int   n_fail = 0;

   snake_dir_queue_if #(.NSRC(2), .DEPTH(2)) bus0 ();
   snake_dir_queue_if #(.NSRC(2), .DEPTH(3)) bus1 ();

   snake_dir_queue #(.NSRC(2), .DEPTH(2), .INIT_DIR(2'b01), .ALLOW_REVERSE(1'b0))
      dut0 (.clock(clock), .reset(reset), .bus(bus0.slave));
   snake_dir_queue #(.NSRC(2), .DEPTH(3), .INIT_DIR(2'b01), .ALLOW_REVERSE(1'b1))
      dut1 (.clock(clock), .reset(reset), .bus(bus1.slave));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int         reps;
      logic       rst, clr, stp;
      logic [1:0] up, rt, dn, lf;
      logic [1:0] dir;
      logic [1:0] cnt;
      logic       trn, ovf;
   } vec_t;

   vec_t tbl[$];
   vec_t cur;

   // reference model state, index 0 -> dut0, 1 -> dut1; directions coded UP=0..LEFT=3
   logic [1:0] m_dir  [2];
   logic [3:0] m_prev [2];
   logic       m_trn  [2];
   logic       m_ovf  [2];
   logic [1:0] m_q    [2][$];
   int         m_depth[2] = '{2, 3};
   bit         m_rev  [2] = '{1'b0, 1'b1};

   function automatic vec_t v(int reps, logic rs, logic cl, logic st,
                              logic [1:0] u, logic [1:0] r, logic [1:0] d, logic [1:0] l,
                              logic [1:0] dir, logic [1:0] cnt, logic t, logic o);
      vec_t x;
      x.reps = reps; x.rst = rs; x.clr = cl; x.stp = st;
      x.up = u; x.rt = r; x.dn = d; x.lf = l;
      x.dir = dir; x.cnt = cnt; x.trn = t; x.ovf = o;
      return x;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step(input int m);
      logic [3:0] lv;
      logic [1:0] cand;
      logic [1:0] refd;
      bit         have, legal, popd;
      int         sz;
      int         order[4] = '{3, 1, 0, 2};
      lv[0] = |cur.up; lv[1] = |cur.rt; lv[2] = |cur.dn; lv[3] = |cur.lf;
      if (cur.rst) begin
         m_dir[m] = 2'b01; m_q[m].delete(); m_prev[m] = 4'hF;
         m_trn[m] = 1'b0; m_ovf[m] = 1'b0;
         return;
      end
      have = 0; cand = 2'b00;
      for (int k = 0; k < 4; k++)
         if (!have && lv[order[k]] && !m_prev[m][order[k]]) begin
            have = 1; cand = 2'(order[k]);
         end
      m_prev[m] = lv; m_trn[m] = 1'b0; m_ovf[m] = 1'b0;
      if (cur.clr) begin
         m_q[m].delete(); m_dir[m] = 2'b01;
         return;
      end
      sz    = m_q[m].size();
      refd  = (sz > 0) ? m_q[m][sz-1] : m_dir[m];
      legal = have && (cand != refd) && (m_rev[m] || cand != 2'(refd + 2'd2));
      popd  = cur.stp && sz > 0;
      if (popd) begin
         m_dir[m] = m_q[m].pop_front();
         m_trn[m] = 1'b1;
      end
      if (legal) begin
         if (sz < m_depth[m] || popd) m_q[m].push_back(cand);
         else m_ovf[m] = 1'b1;
      end
   endtask

   task automatic drive(input vec_t t);
      cur   = t;
      reset = t.rst;
      bus0.src_up = t.up; bus0.src_right = t.rt; bus0.src_down = t.dn; bus0.src_left = t.lf;
      bus0.step = t.stp;  bus0.clear = t.clr;
      bus1.src_up = t.up; bus1.src_right = t.rt; bus1.src_down = t.dn; bus1.src_left = t.lf;
      bus1.step = t.stp;  bus1.clear = t.clr;
   endtask

   task automatic tick_and_check_models();
      @(posedge clock);
      model_step(0);
      model_step(1);
      #1;
      chk("m0 dir", 8'(bus0.direction),   8'(m_dir[0]));
      chk("m0 cnt", 8'(bus0.queue_count), 8'(m_q[0].size()));
      chk("m0 trn", 8'(bus0.turned),      8'(m_trn[0]));
      chk("m0 ovf", 8'(bus0.overflow),    8'(m_ovf[0]));
      chk("m1 dir", 8'(bus1.direction),   8'(m_dir[1]));
      chk("m1 cnt", 8'(bus1.queue_count), 8'(m_q[1].size()));
      chk("m1 trn", 8'(bus1.turned),      8'(m_trn[1]));
      chk("m1 ovf", 8'(bus1.overflow),    8'(m_ovf[1]));
   endtask

   initial begin
      vec_t r;
      logic [7:0] keys;
      drive(v(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));

      //            reps rs cl st  up     rt     dn     lf     dir    cnt t o
      tbl.push_back(v(1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0));
      // basic turn
      tbl.push_back(v(1, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 1, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1, 0, 0));
      tbl.push_back(v(1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0));
      tbl.push_back(v(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 1, 0, 0));
      tbl.push_back(v(1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 1, 0));
      tbl.push_back(v(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0));
      // reversal and redundancy
      tbl.push_back(v(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0));
      // double turn between ticks
      tbl.push_back(v(1, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 1, 0, 0));
      tbl.push_back(v(2, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2, 0, 0));
      tbl.push_back(v(1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0));
      tbl.push_back(v(1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 0, 1, 0));
      tbl.push_back(v(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 0, 0, 0));
      tbl.push_back(v(1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0));
      // overflow, then the same press alongside a step
      tbl.push_back(v(1, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 1, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 2, 0, 1));
      tbl.push_back(v(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2, 0, 0));
      tbl.push_back(v(1, 0, 0, 1, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2, 1, 0));
      tbl.push_back(v(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2, 0, 0));
      // clear beats step and a legal press
      tbl.push_back(v(1, 0, 1, 1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0));
      // held key pushes once
      tbl.push_back(v(10, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 1, 0, 0));
      tbl.push_back(v(1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0));
      // key held through reset is not a press
      tbl.push_back(v(1, 1, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0));
      tbl.push_back(v(3, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0));
      // priority: left over up; right (reverse) wins over down and down is lost
      tbl.push_back(v(1, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 1, 0, 0));
      tbl.push_back(v(1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0));
      tbl.push_back(v(1, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 1, 0, 0));
      tbl.push_back(v(1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 0, 1, 0));
      tbl.push_back(v(1, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b11, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 0, 0, 0));
      // reset overrides clear
      tbl.push_back(v(1, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         for (int k = 0; k < tbl[i].reps; k++) begin
            drive(tbl[i]);
            tick_and_check_models();
            chk($sformatf("row%0d dir", i), 8'(bus0.direction),   8'(tbl[i].dir));
            chk($sformatf("row%0d cnt", i), 8'(bus0.queue_count), 8'(tbl[i].cnt));
            chk($sformatf("row%0d trn", i), 8'(bus0.turned),      8'(tbl[i].trn));
            chk($sformatf("row%0d ovf", i), 8'(bus0.overflow),    8'(tbl[i].ovf));
         end
      end

      keys = 8'h00;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 8; b++)
            if ($urandom_range(0, 5) == 0) keys[b] = ~keys[b];
         r = v(1, ($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
               ($urandom_range(0, 3) == 0), keys[1:0], keys[3:2], keys[5:4], keys[7:6],
               2'b00, 2'b00, 1'b0, 1'b0);
         drive(r);
         tick_and_check_models();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/snake_dir_queue.md
Name: snake_dir_queue

Overview:
Parametrised direction controller for the snake core. It merges turn requests from NSRC input sources (board buttons, PS/2 keyboard, and so on) and edge-detects them. Turns that are legal are buffered in a DEPTH-entry FIFO, so quick double turns between two game ticks are not lost. One queued turn is applied per game step. It replaces the single-register turn logic, which dropped turns and had no reset, flush or overflow reporting.

Parameters:
NSRC, 2, number of request sources ORed per direction (>=1)
DEPTH, 2, turn-queue depth in entries (>=1)
INIT_DIR, 2'b01, direction after reset/clear (RIGHT)
ALLOW_REVERSE, 0, 1 = 180-degree reversal requests accepted

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
src_up  in  NSRC  per-source up level (already synchronised to clock)
src_right  in  NSRC  per-source right level
src_down  in  NSRC  per-source down level
src_left  in  NSRC  per-source left level
step  in  1  one-cycle pulse, the snake advances one cell
clear  in  1  one-cycle pulse, new game: flush queue, restore INIT_DIR
direction  out  2  registered current heading: UP=00 RIGHT=01 DOWN=10 LEFT=11
queue_count  out  $clog2(DEPTH+1)  number of buffered turns
turned  out  1  one-cycle pulse, direction changed on this step
overflow  out  1  one-cycle pulse, a legal request was dropped because the queue was full

Behaviour:
- Reset:
  - direction=INIT_DIR, queue empty, queue_count=0, turned=0, overflow=0.
  - Previous-level registers are set to all 1s, so a key held through reset produces no press.
- Request merge:
  - Each direction's level is the OR across its NSRC sources.
  - A press is that OR at 1 while its previous-level register is 0.
  - Previous-level registers update every cycle, including during clear.
- Simultaneous presses in one cycle: fixed priority LEFT > RIGHT > UP > DOWN. Exactly one press is considered; the others are discarded and never retried.
- Reference direction = queue tail entry if queue non-empty, else direction.
- Acceptance rules for the considered press, checked against the reference direction:
  - If it equals the reference, it is discarded silently.
  - If it equals the reference XOR 2'b10 (reverse) and ALLOW_REVERSE=0, it is discarded silently.
  - Otherwise it is legal. A legal press is pushed at that clock edge if the queue has space.
  - If the queue is full, the legal press is dropped and overflow=1 for the next cycle only.
- Step with queue non-empty: direction <= head, pop, turned=1 for one cycle (always a real change by construction).
- Step with queue empty: direction holds, turned=0.
- Push and pop in the same cycle:
  - Both occur and queue_count is unchanged.
  - The press is checked against the pre-pop tail.
  - Full queue plus step plus legal press: the pop frees a slot, so the press is accepted with no overflow.
- Push into an empty queue on a step cycle: no bypass. The entry is applied at the next step, so minimum latency from press to heading change is one step.
- Clear (highest priority over step and push):
  - Queue emptied, direction=INIT_DIR, turned=0.
  - A press in the same cycle is discarded with no overflow.
- Reset overrides clear.
- Pointers are wrap-around mod DEPTH; DEPTH need not be a power of two.
- queue_count never exceeds DEPTH.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
1. Basic turn:
   - Stimulus: reset, INIT_DIR=01. Pulse src_up[0] for 1 cycle, then step.
   - Required: queue_count goes 0→1→0; direction=00; turned high exactly 1 cycle.
2. Reversal and redundancy:
   - Stimulus: direction 01; press src_left[1]; press src_right[0]; then step.
   - Required: queue_count stays 0; direction stays 01; turned=0. With ALLOW_REVERSE=1 the left press is queued and the step gives direction=11.
3. Double turn between ticks:
   - Stimulus: direction 01; press up, then left 3 cycles later; then two steps.
   - Required: queue_count=2 (left accepted against tail 00); steps give direction 00 then 11.
4. Overflow, DEPTH=2:
   - Stimulus: direction 01; press up, left, then down.
   - Required: down (reference 11, perpendicular) is dropped; overflow pulses 1 cycle; queue_count=2.
   - Follow-up: repeat the down press in the same cycle as a step. Required: accepted, no overflow, queue_count=2.
5. Held keys and priority:
   - Held key: hold src_up[0] 10 cycles. Required: exactly one push.
   - Held through reset: hold src_up[0] across reset. Required: no push.
   - Priority: press left and up in the same cycle from direction 00. Required: left queued; up discarded.
6. Clear:
   - Stimulus: queue holding 2 entries; assert clear together with step and a legal press.
   - Required: queue_count=0, direction=INIT_DIR, turned=0, overflow=0.
